multicycle_ctrl: RTL

Multi-cycle sequencer for the single-issue MIPS-subset datapath: R-type (ADD, SUB, AND, OR, XOR, NOR), ADDI, LW and SW. It replaces the purely combinational control decode. It steps each instruction through fetch/decode/execute/memory/writeback states and drives the datapath enables, ALU function and memory handshake. It also counts retired instructions and halts on illegal encodings or memory timeouts.

---
 rtl/multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the MIPS-subset datapath.
// It steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables, the ALU function and the memory handshake.
// Outputs are Moore decodes of the state register. The exceptions are
// ir_write and pc_write, which follow mem_ready inside FETCH.
// The block counts retired instructions. It halts with sticky flags on an
// illegal encoding or on a memory wait timeout.
module multicycle_ctrl #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [5:0]       alu_func,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic [1:0]       data_size,
   output logic [3:0]       state,
   output logic             busy,
   output logic             illegal,
   output logic             timeout,
   output logic [CNT_W-1:0] retired
);

   // State encodings (visible on the debug state port)
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC_R = 4'd2;
   localparam logic [3:0] S_EXEC_I = 4'd3;
   localparam logic [3:0] S_ADDR   = 4'd4;
   localparam logic [3:0] S_MEM_RD = 4'd5;
   localparam logic [3:0] S_MEM_WR = 4'd6;
   localparam logic [3:0] S_WB_R   = 4'd7;
   localparam logic [3:0] S_WB_I   = 4'd8;
   localparam logic [3:0] S_WB_MEM = 4'd9;
   localparam logic [3:0] S_HALT   = 4'd10;

   // Instruction encodings
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_ADD   = 6'b100000;

   // The counter only needs to reach WAIT_LIMIT: the FSM leaves the wait state at the limit
   localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_LIMIT);

   // Supported R-type function codes: ADD, SUB, AND, OR, XOR, NOR
   function automatic logic legal_rfunct(input logic [5:0] f);
      logic ok;
      case (f)
         6'b100000: ok = 1'b1;
         6'b100010: ok = 1'b1;
         6'b100100: ok = 1'b1;
         6'b100101: ok = 1'b1;
         6'b100110: ok = 1'b1;
         6'b100111: ok = 1'b1;
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // States that hold a memory request open until mem_ready
   function automatic logic is_wait_state(input logic [3:0] s);
      logic w;
      case (s)
         S_FETCH:  w = 1'b1;
         S_MEM_RD: w = 1'b1;
         S_MEM_WR: w = 1'b1;
         default:  w = 1'b0;
      endcase
      return w;
   endfunction

   logic [3:0]        state_q,    state_d;
   logic              is_store_q, is_store_d;
   logic              illegal_q,  illegal_d;
   logic              timeout_q,  timeout_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  retired_q,  retired_d;
   logic              retire_s;
   logic              wait_limit_s;

   // A memory state has used up its allowance of wait cycles
   assign wait_limit_s = (wait_cnt_q == WAIT_MAX);

   // Next-state logic, sticky error flags and retire strobe
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      retire_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_limit_s) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if ((opcode == OP_RTYPE) && legal_rfunct(funct)) begin
               state_d = S_EXEC_R;
            end else if (opcode == OP_ADDI) begin
               state_d = S_EXEC_I;
            end else if (opcode == OP_LW) begin
               state_d    = S_ADDR;
               is_store_d = 1'b0;
            end else if (opcode == OP_SW) begin
               state_d    = S_ADDR;
               is_store_d = 1'b1;
            end else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_EXEC_R: state_d = S_WB_R;
         S_EXEC_I: state_d = S_WB_I;
         // Load/store was resolved in DECODE; opcode is not looked at again here
         S_ADDR: begin
            if (is_store_q) begin
               state_d = S_MEM_WR;
            end else begin
               state_d = S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            if (mem_ready) begin
               state_d = S_WB_MEM;
            end else if (wait_limit_s) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end else begin
               state_d = S_MEM_RD;
            end
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d  = S_FETCH;
               retire_s = 1'b1;
            end else if (wait_limit_s) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
            end else begin
               state_d = S_MEM_WR;
            end
         end
         S_WB_R, S_WB_I, S_WB_MEM: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         // Any unused code is treated as a fault and parks the sequencer
         default: state_d = S_HALT;
      endcase
   end

   // Wait counter: cleared on every state change, counts not-ready cycles in memory states
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (is_wait_state(state_q) && !mem_ready && !wait_limit_s) begin
         wait_cnt_d = wait_cnt_q + WCNT_W'(1);
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_comb begin
      if (retire_s) begin
         retired_d = retired_q + CNT_W'(1);
      end else begin
         retired_d = retired_q;
      end
   end

   // Sequencer registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         is_store_q <= 1'b0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         wait_cnt_q <= '0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         wait_cnt_q <= wait_cnt_d;
         retired_q  <= retired_d;
      end
   end

   // Datapath control decode; the strobes are gated by rst_n so they drop during reset
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_func   = 6'b000000;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      data_size  = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_read  = rst_n;
            i_or_d    = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b01;
            alu_func  = FN_ADD;
            ir_write  = mem_ready & rst_n;
            pc_write  = mem_ready & rst_n;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_func  = funct;
         end
         S_EXEC_I, S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_func  = FN_ADD;
         end
         S_MEM_RD: begin
            mem_read  = rst_n;
            i_or_d    = 1'b1;
            data_size = 2'b10;
         end
         S_MEM_WR: begin
            mem_write = rst_n;
            i_or_d    = 1'b1;
            data_size = 2'b10;
         end
         S_WB_R: begin
            reg_write = rst_n;
            reg_dst   = 1'b1;
         end
         S_WB_I: begin
            reg_write = rst_n;
            reg_dst   = 1'b0;
         end
         S_WB_MEM: begin
            reg_write  = rst_n;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b1;
         end
         // DECODE and HALT drive no enables
         default: begin
            pc_write = 1'b0;
         end
      endcase
   end

   assign state   = state_q;
   assign busy    = (state_q != S_HALT);
   assign illegal = illegal_q;
   assign timeout = timeout_q;
   assign retired = retired_q;

endmodule
